// File: rtl/prescaler_bank_if.sv
// Bus bundle between the register bank and prescaler_bank: divider/enable/mode controls in,
// tick/f strobes out. The phase vector exists only when PRESCALER_PHASE_EN is defined.
interface prescaler_bank_if #(
  parameter int CHANNELS = 4,
  parameter int BITS     = 32
);
  logic [CHANNELS-1:0]      en;
  logic [CHANNELS-1:0]      mode;
  logic [BITS*CHANNELS-1:0] div;
  logic                     sync;
`ifdef PRESCALER_PHASE_EN
  logic [BITS*CHANNELS-1:0] phase;
`endif
  logic [CHANNELS-1:0]      tick;
  logic [CHANNELS-1:0]      f;

`ifdef PRESCALER_PHASE_EN
  modport master (output en, mode, div, sync, phase, input tick, f);
  modport slave  (input en, mode, div, sync, phase, output tick, f);
`else
  modport master (output en, mode, div, sync, input tick, f);
  modport slave  (input en, mode, div, sync, output tick, f);
`endif
endinterface

// File: rtl/prescaler_bank.sv
// Multi-channel programmable clock-enable generator with toggle/pulse modes and common sync.
// Optional feature macro: PRESCALER_PHASE_EN (adds per-channel phase skew loaded on sync).
module prescaler_bank #(
  parameter int CHANNELS = 4,
  parameter int BITS     = 32
) (
  input  logic                clk,
  input  logic                rst,
  prescaler_bank_if.slave     bus
);

  logic [BITS-1:0]     cnt       [CHANNELS];
  logic [BITS-1:0]     d_eff     [CHANNELS];
  logic [BITS-1:0]     reload    [CHANNELS];
  logic [BITS-1:0]     sync_load [CHANNELS];
  logic [CHANNELS-1:0] tick_r;
  logic [CHANNELS-1:0] f_r;

  // A zero divider behaves as divide-by-one so a channel can never stall.
  function automatic logic [BITS-1:0] eff_div(input logic [BITS-1:0] d);
    return (d == '0) ? BITS'(1) : d;
  endfunction

`ifdef PRESCALER_PHASE_EN
  // Out-of-range phases clip to the longest possible wait within one period.
  function automatic logic [BITS-1:0] phase_load(input logic [BITS-1:0] ph,
                                                 input logic [BITS-1:0] d);
    return (ph < d) ? ph : d - BITS'(1);
  endfunction
`endif

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      d_eff[i]  = eff_div(bus.div[BITS*i +: BITS]);
      reload[i] = d_eff[i] - BITS'(1);
`ifdef PRESCALER_PHASE_EN
      sync_load[i] = phase_load(bus.phase[BITS*i +: BITS], d_eff[i]);
`else
      sync_load[i] = reload[i];
`endif
    end
  end

  // div is only consumed at reload points, so in-flight periods finish with the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
      tick_r <= '0;
      f_r    <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.sync) begin
          cnt[i]    <= sync_load[i];
          tick_r[i] <= 1'b0;
          f_r[i]    <= 1'b0;
        end else if (!bus.en[i]) begin
          tick_r[i] <= 1'b0;
        end else if (cnt[i] == '0) begin
          cnt[i]    <= reload[i];
          tick_r[i] <= 1'b1;
          f_r[i]    <= bus.mode[i] ? 1'b1 : ~f_r[i];
        end else begin
          cnt[i]    <= cnt[i] - BITS'(1);
          tick_r[i] <= 1'b0;
          if (bus.mode[i]) f_r[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.tick = tick_r;
  assign bus.f    = f_r;

endmodule

// File: tb/tb_prescaler_bank.sv
// Self-checking bench for prescaler_bank: reset/mode table, directed multi-cycle corners,
// and randomized traffic compared against an edges-to-next-tick reference model.
module tb_prescaler_bank;
  localparam int CH = 4;
  localparam int B  = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  prescaler_bank_if #(.CHANNELS(CH), .BITS(B)) bus ();

  prescaler_bank #(.CHANNELS(CH), .BITS(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: for each channel, the number of enabled edges still to go until the
  // edge that produces a tick (1 means the next enabled edge ticks).
  longint togo [CH];
  bit     mt   [CH];
  bit     mf   [CH];
  int     first_at [CH];

  function automatic longint ref_div(int c);
    longint d;
    d = longint'(bus.div[B*c +: B]);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic longint ref_wait_after_sync(int c);
    longint d;
    d = ref_div(c);
`ifdef PRESCALER_PHASE_EN
    begin
      longint ph;
      ph = longint'(bus.phase[B*c +: B]);
      return (ph < d) ? ph + 1 : d;
    end
`else
    return d;
`endif
  endfunction

  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      if (rst) begin
        togo[c] = 1; mt[c] = 0; mf[c] = 0;
      end else if (bus.sync) begin
        togo[c] = ref_wait_after_sync(c); mt[c] = 0; mf[c] = 0;
      end else if (!bus.en[c]) begin
        mt[c] = 0;
      end else if (togo[c] == 1) begin
        mt[c] = 1;
        togo[c] = ref_div(c);
        mf[c] = bus.mode[c] ? 1'b1 : ~mf[c];
      end else begin
        mt[c] = 0;
        togo[c] = togo[c] - 1;
        if (bus.mode[c]) mf[c] = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [CH-1:0] et, ef;
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < CH; c++) begin
      et[c] = mt[c];
      ef[c] = mf[c];
    end
    chk("model_tick", 32'(bus.tick), 32'(et));
    chk("model_f", 32'(bus.f), 32'(ef));
    @(negedge clk);
  endtask

  task automatic set_div(input int c, input logic [31:0] v);
    bus.div[B*c +: B] = v;
  endtask

  task automatic run_first(input int n);
    for (int c = 0; c < CH; c++) first_at[c] = 0;
    for (int k = 1; k <= n; k++) begin
      step();
      for (int c = 0; c < CH; c++)
        if (bus.tick[c] && first_at[c] == 0) first_at[c] = k;
    end
  endtask

  typedef struct {
    logic       rst;
    logic       sync;
    logic [3:0] en;
    logic [3:0] tick;
    logic [3:0] f;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int ticks, highs;
    logic held_f;

    // ch0 div2 toggle, ch1 div3 pulse, ch2 div0 toggle, ch3 div1 pulse
    tbl[0] = '{1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0000};
    tbl[1] = '{1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0000};
    tbl[2] = '{1'b0, 1'b0, 4'b1111, 4'b1111, 4'b1111};
    tbl[3] = '{1'b0, 1'b0, 4'b1111, 4'b1100, 4'b1001};
    tbl[4] = '{1'b0, 1'b0, 4'b1111, 4'b1101, 4'b1100};
    tbl[5] = '{1'b0, 1'b0, 4'b1111, 4'b1110, 4'b1010};
    tbl[6] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1010};
    tbl[7] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000};
    tbl[8] = '{1'b0, 1'b0, 4'b1111, 4'b1100, 4'b1100};

    rst = 1'b1;
    bus.sync = 1'b0;
    bus.en = 4'b1111;
    bus.mode = 4'b1010;
    bus.div = '0;
`ifdef PRESCALER_PHASE_EN
    bus.phase = '1;
`endif
    set_div(0, 2); set_div(1, 3); set_div(2, 0); set_div(3, 1);
    for (int c = 0; c < CH; c++) begin togo[c] = 1; mt[c] = 0; mf[c] = 0; end
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst;
      bus.sync = tbl[i].sync;
      bus.en = tbl[i].en;
      step();
      chk($sformatf("tbl%0d_tick", i), 32'(bus.tick), 32'(tbl[i].tick));
      chk($sformatf("tbl%0d_f", i), 32'(bus.f), 32'(tbl[i].f));
    end
    bus.sync = 1'b0;

    // Toggle mode, div 5: ticks every 5, f square wave with period 10
    bus.en = 4'b0001; bus.mode = 4'b0000; set_div(0, 5);
    bus.sync = 1'b1; step(); bus.sync = 1'b0;
    ticks = 0; highs = 0;
    for (int c = 0; c < CH; c++) first_at[c] = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus.tick[0]) begin ticks++; if (first_at[0] == 0) first_at[0] = k; end
      if (k >= 5 && k <= 14 && bus.f[0]) highs++;
    end
    chk("div5_first_tick", first_at[0], 5);
    chk("div5_tick_count", ticks, 4);
    chk("div5_f_high", highs, 5);

    // Divider change mid-period: in-flight period finishes with old value
    set_div(0, 8);
    bus.sync = 1'b1; step(); bus.sync = 1'b0;
    step(); step();
    set_div(0, 2);
    run_first(6);
    chk("divchg_old_period", first_at[0], 6);
    run_first(3);
    chk("divchg_new_period", first_at[0], 2);

    // Hold: en0 low freezes f and suppresses tick
    bus.en = 4'b1111; bus.mode = 4'b0000;
    set_div(0, 4); set_div(1, 6); set_div(2, 6); set_div(3, 4);
    step(); step(); step();
    held_f = bus.f[0];
    bus.en = 4'b1110;
    ticks = 0; highs = 0;
    for (int k = 0; k < 7; k++) begin
      step();
      if (bus.tick[0]) ticks++;
      if (bus.f[0] != held_f) highs++;
    end
    chk("hold_tick", ticks, 0);
    chk("hold_f_changes", highs, 0);
    bus.en = 4'b1111;
    bus.sync = 1'b1; step(); bus.sync = 1'b0;
    run_first(5);
    chk("sync_ch0_first", first_at[0], 4);
    chk("sync_ch3_first", first_at[3], 4);

`ifdef PRESCALER_PHASE_EN
    // Programmable skew: phase 3 and clipped phase 12 with div 10
    set_div(0, 10); set_div(1, 10);
    bus.phase[0 +: B] = 3;
    bus.phase[B +: B] = 12;
    bus.sync = 1'b1; step(); bus.sync = 1'b0;
    run_first(12);
    chk("phase_ch0_first", first_at[0], 4);
    chk("phase_ch1_first", first_at[1], 10);
    bus.phase = '1;
`endif

    // Randomized traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      bus.sync = ($urandom_range(0, 24) == 0);
      bus.en = 4'($urandom | $urandom);
      if ($urandom_range(0, 9) == 0) bus.mode = 4'($urandom);
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 7) == 0) set_div(c, $urandom_range(0, 7));
`ifdef PRESCALER_PHASE_EN
        if ($urandom_range(0, 7) == 0) bus.phase[B*c +: B] = $urandom_range(0, 9);
`endif
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
